// File: rtl/alu_uart_link_pkg.sv
// alu_uart_link_pkg: FSM state type and ALU opcode encodings shared by the link and the ALU.
package alu_uart_link_pkg;
    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_e;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;
endpackage

// File: rtl/alu_uart_link_op_check.sv
// alu_op_check: combinational decoder flagging opcodes the ALU implements (used under ALU_OP_CHECK_EN).
module alu_op_check
    import alu_uart_link_pkg::*;
#(
    parameter int N_OP = 6
) (
    input  logic [N_OP-1:0] op,
    output logic            valid
);
    always_comb begin
        valid = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR)
             || (op == OP_XOR) || (op == OP_SRA) || (op == OP_SRL) || (op == OP_NOR);
    end
endmodule

// File: rtl/alu_uart_link.sv
// alu_uart_link: gathers A, B and opcode bytes from the UART receiver, drives the ALU and sends its result.
// Define ALU_OP_CHECK_EN to reject unsupported opcodes with an op_err pulse instead of transmitting.
module alu_uart_link
    import alu_uart_link_pkg::*;
#(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] rx_data,
    input  logic              rx_valid,
    output logic [N_BITS-1:0] alu_a,
    output logic [N_BITS-1:0] alu_b,
    output logic [N_OP-1:0]   alu_op,
    input  logic [N_BITS-1:0] alu_result,
    output logic [N_BITS-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy,
    output logic              op_err
);
    state_e            state_q, state_d;
    logic [N_BITS-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, tx_data_q, tx_data_d;
    logic [N_OP-1:0]   alu_op_q, alu_op_d;
    logic              tx_start_q, tx_start_d, busy_q, busy_d, op_err_q, op_err_d;
    logic              op_ok;

`ifdef ALU_OP_CHECK_EN
    alu_op_check #(.N_OP(N_OP)) u_op_check (
        .op    (rx_data[N_OP-1:0]),
        .valid (op_ok)
    );
`else
    assign op_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        op_err_d   = 1'b0;
        case (state_q)
            WAIT_A: if (rx_valid) begin
                alu_a_d = rx_data;
                state_d = WAIT_B;
            end
            WAIT_B: if (rx_valid) begin
                alu_b_d = rx_data;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (rx_valid) begin
                if (op_ok) begin
                    alu_op_d = rx_data[N_OP-1:0];
                    state_d  = EXEC;
                end else begin
                    op_err_d = 1'b1;
                    state_d  = WAIT_A;
                end
            end
            // alu_op has been stable for a full cycle here, so the ALU output is settled
            EXEC: begin
                tx_data_d  = alu_result;
                tx_start_d = 1'b1;
                state_d    = SEND;
            end
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (tx_done) state_d = WAIT_A;
            default: state_d = WAIT_A;
        endcase
        busy_d = (state_d != WAIT_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            op_err_q   <= op_err_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign op_err   = op_err_q;
endmodule

// File: tb/tb_alu_uart_link.sv
// tb_alu_uart_link: directed byte frames against alu_uart_link with a behavioural ALU behind it.
// Honours ALU_OP_CHECK_EN for the bad-opcode frame.
module tb_alu_uart_link;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] alu_a, alu_b, alu_result, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, tx_done = 1'b0, busy, op_err;
    int         total = 0;
    int         bad = 0;

    alu_uart_link dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .busy       (busy),
        .op_err     (op_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            6'h03:   alu_result = $signed(alu_a) >>> alu_b;
            6'h02:   alu_result = alu_a >> alu_b;
            6'h27:   alu_result = ~(alu_a | alu_b);
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("busy_after_done", busy, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [5:0] exp_op, input logic [7:0] exp_res);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check({tag, "_a"}, alu_a, a);
        check({tag, "_b"}, alu_b, b);
        check({tag, "_op"}, alu_op, exp_op);
        check({tag, "_start_exec"}, tx_start, 0);
        check({tag, "_busy"}, busy, 1);
        @(negedge clk);
        check({tag, "_start_hi"}, tx_start, 1);
        check({tag, "_txdata"}, tx_data, exp_res);
        @(negedge clk);
        check({tag, "_start_lo"}, tx_start, 0);
        check({tag, "_txdata_hold"}, tx_data, exp_res);
    endtask

    initial begin
        #2;
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_op", alu_op, 0);
        check("rst_tx", {tx_data, tx_start, busy, op_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        pulse_done();
        run_frame("sra", 8'hF0, 8'h02, 8'h03, 6'h03, 8'hFC);
        pulse_done();
        run_frame("sub", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
        pulse_done();

`ifdef ALU_OP_CHECK_EN
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h3F);
        check("bad_err", op_err, 1);
        check("bad_busy", busy, 0);
        check("bad_start", tx_start, 0);
        check("bad_op_kept", alu_op, 6'h22);
        @(negedge clk);
        check("bad_err_lo", op_err, 0);
        check("bad_start2", tx_start, 0);
        check("bad_busy2", busy, 0);
`else
        run_frame("bad", 8'h01, 8'h01, 8'h3F, 6'h3F, 8'h00);
        check("bad_err_tied", op_err, 0);
        pulse_done();
`endif

        run_frame("pre", 8'h04, 8'h04, 8'h20, 6'h20, 8'h08);
        send_byte(8'hAA);
        check("drop_busy", busy, 1);
        check("drop_a", alu_a, 8'h04);
        @(negedge clk);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        tx_done  = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        check("same_cycle_busy", busy, 0);
        check("same_cycle_a", alu_a, 8'h04);
        run_frame("or", 8'h01, 8'h02, 8'h25, 6'h25, 8'h03);
        pulse_done();

        send_byte(8'h07);
        check("mid_a", alu_a, 8'h07);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a", alu_a, 0);
        check("arst_op", alu_op, 0);
        check("arst_tx", {tx_data, tx_start, busy, op_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst", 8'h07, 8'h01, 8'h20, 6'h20, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_send", tx_start, 0);
        check("rst_in_send_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame("upper", 8'h05, 8'h03, 8'hE0, 6'h20, 8'h08);
        pulse_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
